fnd_tick_counter: RTL and testbench
===================================

FND_TICK_COUNTER -- requirements
Module: fnd_tick_counter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 9999, meaning terminal count (0..9999) before wrap to 0.
REQ-002 SHALL have port i_clk  input  1  system clock (100 MHz); all logic on its rising edge only.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_tick  input  1  10 Hz square wave from the clock divider, synchronous to i_clk.
REQ-005 SHALL have port i_run_stop  input  1  single-cycle pulse; toggles STOP/RUN.
REQ-006 SHALL have port i_clear  input  1  single-cycle pulse; zeroes the count.
REQ-007 SHALL have port o_count  output  14  binary count value.
REQ-008 SHALL have ports o_bcd_1000, o_bcd_100, o_bcd_10, o_bcd_1  output  4 each  BCD digits of o_count for the FND driver.
REQ-009 SHALL have port o_running  output  1  high in RUN state.
REQ-010 SHALL have port o_wrap  output  1  one-cycle pulse on MAX_COUNT -> 0 rollover.

Function
REQ-011 SHALL register i_tick into r_tick_d each cycle; tick event = i_tick & ~r_tick_d (rising edge only; falling edge ignored).
REQ-012 SHALL implement a two-state FSM: STOP (o_running=0), RUN (o_running=1); i_run_stop=1 toggles state at that clock edge; otherwise state holds.
REQ-013 SHALL increment the count at the clock edge where a tick event is detected and the current (pre-toggle) state is RUN; new value visible the following cycle.
REQ-014 SHALL, when the count equals MAX_COUNT at an increment, load 0 and assert o_wrap for exactly that one following cycle; o_wrap SHALL be 0 at all other times.
REQ-015 SHALL keep BCD digits as cascaded decimal counters (each 0..9, carry to next digit at 9), always equal to the decimal digits of o_count in the same cycle; no digit SHALL ever hold 10..15.
REQ-016 SHALL give priority: i_reset > i_clear > increment; i_clear with a simultaneous tick event yields count 0, o_wrap 0.
REQ-017 SHALL leave FSM state unchanged on i_clear; i_clear and i_run_stop in the same cycle both take effect.
REQ-018 SHALL hold the count while in STOP; a tick event in STOP is discarded, not deferred.
REQ-019 SHALL not count on STOP->RUN while i_tick is already high; first increment occurs at the next rising edge of i_tick.
REQ-020 SHALL treat i_run_stop/i_clear as level-sampled each cycle; a pulse held N cycles toggles N times (debounce/one-shot is upstream's job).
REQ-021 SHALL, with MAX_COUNT < 9999, wrap at MAX_COUNT with digits consistent per REQ-015.

Reset
REQ-022 SHALL, on i_clk edge with i_reset=1, set state STOP, count 0, all BCD digits 0, r_tick_d 0, o_wrap 0, o_running 0.
REQ-023 SHALL, with reset asserted mid-count, override all other inputs in that cycle; output reset values visible the following cycle.
REQ-024 SHALL resume from STOP/0 after reset release; no spurious increment even if i_tick is high at release.

Verification
REQ-025 SHALL cover: reset, pulse i_run_stop, drive 25 i_tick rising edges -> o_count=25, digits 0/0/2/5, o_running=1.
REQ-026 SHALL cover: preload to 9999 via ticks (or MAX_COUNT=12 build), one more tick -> o_count=0, all digits 0, o_wrap high exactly 1 cycle.
REQ-027 SHALL cover: RUN at count 7, i_run_stop pulse, 5 tick edges -> count stays 7; i_run_stop again, 1 edge -> 8.
REQ-028 SHALL cover: i_clear coincident with tick edge at count 42 -> count 0, o_wrap 0, o_running unchanged (1).
REQ-029 SHALL cover: i_run_stop asserted while i_tick high -> no increment until the next 0->1 transition of i_tick; tick held high 10 cycles -> exactly 1 increment.
REQ-030 SHALL cover: i_reset asserted at count 1234 in RUN with simultaneous tick edge -> next cycle count 0, digits 0, o_running 0.

Source files
------------

// File: rtl/fnd_tick_counter_if.sv
// Control and display bus of the tick counter: pulse inputs from the
// button/divider side and the binary/BCD count going to the FND driver.
interface fnd_tick_counter_if;
  logic        i_tick;
  logic        i_run_stop;
  logic        i_clear;
  logic [13:0] o_count;
  logic [3:0]  o_bcd_1000;
  logic [3:0]  o_bcd_100;
  logic [3:0]  o_bcd_10;
  logic [3:0]  o_bcd_1;
  logic        o_running;
  logic        o_wrap;

  modport master (
    output i_tick, i_run_stop, i_clear,
    input  o_count, o_bcd_1000, o_bcd_100, o_bcd_10, o_bcd_1, o_running, o_wrap
  );

  modport slave (
    input  i_tick, i_run_stop, i_clear,
    output o_count, o_bcd_1000, o_bcd_100, o_bcd_10, o_bcd_1, o_running, o_wrap
  );
endinterface

// File: rtl/fnd_tick_counter.sv
// Run/stop tick counter: counts rising edges of i_tick while running, wraps at
// MAX_COUNT, and keeps a cascaded BCD copy of the count for a 4-digit FND.
module fnd_tick_counter #(
  parameter int MAX_COUNT = 9999
) (
  input  logic               i_clk,
  input  logic               i_reset,
  fnd_tick_counter_if.slave  bus
);

  localparam logic [13:0] L_MAX = 14'(MAX_COUNT);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_tick_d;
  logic [13:0]      r_count;
  logic [3:0][3:0]  r_bcd;
  logic             r_wrap;

  logic             w_tick_evt;
  logic             w_inc;
  logic             w_at_max;
  logic [13:0]      w_count_nxt;
  logic [3:0][3:0]  w_bcd_nxt;
  logic             w_wrap_nxt;

  // Ripple a +1 through four decimal digits; index 0 is the ones digit.
  function automatic logic [3:0][3:0] bcd_inc(input logic [3:0][3:0] d);
    logic [3:0][3:0] res;
    logic            carry;
    res   = d;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (d[i] >= 4'd9) begin
          res[i] = 4'd0;
        end else begin
          res[i] = d[i] + 4'd1;
          carry  = 1'b0;
        end
      end else begin
        res[i] = d[i];
      end
    end
    return res;
  endfunction

  // Tick delay register for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tick_d <= 1'b0;
    end else begin
      r_tick_d <= bus.i_tick;
    end
  end

  // Run/stop state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: each sampled run/stop level flips the state.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_run_stop) begin
      case (r_state)
        ST_STOP: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_STOP;
        default: w_state_nxt = ST_STOP;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Increment uses the state before any toggle in the same cycle.
  assign w_tick_evt = bus.i_tick & ~r_tick_d;
  assign w_inc      = w_tick_evt & (r_state == ST_RUN);
  assign w_at_max   = (r_count == L_MAX);

  // Next count: clear beats increment; rollover raises a one-cycle wrap.
  always_comb begin
    w_count_nxt = r_count;
    w_bcd_nxt   = r_bcd;
    w_wrap_nxt  = 1'b0;
    if (bus.i_clear) begin
      w_count_nxt = 14'd0;
      w_bcd_nxt   = '0;
    end else if (w_inc) begin
      if (w_at_max) begin
        w_count_nxt = 14'd0;
        w_bcd_nxt   = '0;
        w_wrap_nxt  = 1'b1;
      end else begin
        w_count_nxt = r_count + 14'd1;
        w_bcd_nxt   = bcd_inc(r_bcd);
      end
    end else begin
      w_count_nxt = r_count;
      w_bcd_nxt   = r_bcd;
    end
  end

  // Count, BCD digits and wrap pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 14'd0;
      r_bcd   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_bcd   <= w_bcd_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.o_count    = r_count;
  assign bus.o_bcd_1000 = r_bcd[3];
  assign bus.o_bcd_100  = r_bcd[2];
  assign bus.o_bcd_10   = r_bcd[1];
  assign bus.o_bcd_1    = r_bcd[0];
  assign bus.o_running  = (r_state == ST_RUN);
  assign bus.o_wrap     = r_wrap;

endmodule

// File: tb/tb_fnd_tick_counter.sv
// Scoreboard bench for fnd_tick_counter: default build plus a MAX_COUNT=12
// build share stimulus; a decimal model predicts every cycle's outputs.
module tb_fnd_tick_counter;

  logic clk;
  logic reset;

  fnd_tick_counter_if u_if ();
  fnd_tick_counter_if u_if12 ();

  fnd_tick_counter #(.MAX_COUNT(9999)) u_dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (u_if)
  );

  fnd_tick_counter #(.MAX_COUNT(12)) u_dut12 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (u_if12)
  );

  typedef struct {
    int cnt;
    int cnt12;
    bit run;
    bit wrap;
    bit wrap12;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt   = 0;
  int m_cnt12 = 0;
  bit m_run   = 1'b0;
  bit m_prev  = 1'b0;
  bit m_wrap  = 1'b0;
  bit m_wrap12 = 1'b0;
  logic cur_tick = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dec4(input int c);
    return {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, predict the outputs after the next edge.
  task automatic step(input logic t, input logic rs, input logic clr, input logic rst);
    exp_t e;
    bit ev;
    reset = rst;
    u_if.i_tick = t;     u_if.i_run_stop = rs;   u_if.i_clear = clr;
    u_if12.i_tick = t;   u_if12.i_run_stop = rs; u_if12.i_clear = clr;
    cur_tick = t;
    if (rst) begin
      m_cnt = 0; m_cnt12 = 0; m_run = 1'b0; m_prev = 1'b0;
      m_wrap = 1'b0; m_wrap12 = 1'b0;
    end else begin
      ev = t && !m_prev;
      m_prev = t;
      m_wrap = 1'b0;
      m_wrap12 = 1'b0;
      if (clr) begin
        m_cnt = 0;
        m_cnt12 = 0;
      end else if (ev && m_run) begin
        m_wrap   = (m_cnt == 9999);
        m_cnt    = (m_cnt + 1) % 10000;
        m_wrap12 = (m_cnt12 == 12);
        m_cnt12  = (m_cnt12 + 1) % 13;
      end
      if (rs) m_run = !m_run;
    end
    e.cnt = m_cnt; e.cnt12 = m_cnt12; e.run = m_run;
    e.wrap = m_wrap; e.wrap12 = m_wrap12;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic tick_edges(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_rs();
    step(cur_tick, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    step(cur_tick, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: the outputs are presented every cycle; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count",    {2'b00, u_if.o_count}, 16'(e.cnt));
        chk("digits",   {u_if.o_bcd_1000, u_if.o_bcd_100, u_if.o_bcd_10, u_if.o_bcd_1}, dec4(e.cnt));
        chk("running",  {15'd0, u_if.o_running}, {15'd0, e.run});
        chk("wrap",     {15'd0, u_if.o_wrap}, {15'd0, e.wrap});
        chk("count12",  {2'b00, u_if12.o_count}, 16'(e.cnt12));
        chk("digits12", {u_if12.o_bcd_1000, u_if12.o_bcd_100, u_if12.o_bcd_10, u_if12.o_bcd_1}, dec4(e.cnt12));
        chk("running12", {15'd0, u_if12.o_running}, {15'd0, e.run});
        chk("wrap12",   {15'd0, u_if12.o_wrap}, {15'd0, e.wrap12});
      end
    end
  end

  initial begin
    #(700_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    u_if.i_tick = 1'b0;   u_if.i_run_stop = 1'b0;   u_if.i_clear = 1'b0;
    u_if12.i_tick = 1'b0; u_if12.i_run_stop = 1'b0; u_if12.i_clear = 1'b0;

    // Reset with tick high; no increment after release even when running.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_count", {2'b00, u_if.o_count}, 16'd0);
    chk("reset_running", {15'd0, u_if.o_running}, 16'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("release_count", {2'b00, u_if.o_count}, 16'd0);

    // 25 tick edges in RUN.
    tick_edges(25);
    chk("r25_count", {2'b00, u_if.o_count}, 16'd25);
    chk("r25_digits", {u_if.o_bcd_1000, u_if.o_bcd_100, u_if.o_bcd_10, u_if.o_bcd_1}, 16'h0025);
    chk("r25_running", {15'd0, u_if.o_running}, 16'd1);

    // Stop holds the count; tick edges in STOP are discarded.
    pulse_clr();
    tick_edges(7);
    pulse_rs();
    tick_edges(5);
    chk("stop_hold", {2'b00, u_if.o_count}, 16'd7);
    pulse_rs();
    tick_edges(1);
    chk("resume_count", {2'b00, u_if.o_count}, 16'd8);

    // Clear coincident with a tick edge at 42.
    pulse_clr();
    tick_edges(42);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_count", {2'b00, u_if.o_count}, 16'd0);
    chk("clr_wrap", {15'd0, u_if.o_wrap}, 16'd0);
    chk("clr_running", {15'd0, u_if.o_running}, 16'd1);

    // Enter RUN while tick is already high; long high tick counts once.
    pulse_rs();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("runhigh_count", {2'b00, u_if.o_count}, 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("longtick_count", {2'b00, u_if.o_count}, 16'd1);

    // Randomized traffic, including occasional clears, toggles and resets.
    repeat (600) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 127) == 0));
    end

    // Reset mid-count at 1234 with a simultaneous tick edge.
    pulse_clr();
    if (!m_run) pulse_rs();
    tick_edges(1234);
    chk("c1234_digits", {u_if.o_bcd_1000, u_if.o_bcd_100, u_if.o_bcd_10, u_if.o_bcd_1}, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst1234_count", {2'b00, u_if.o_count}, 16'd0);
    chk("rst1234_digits", {u_if.o_bcd_1000, u_if.o_bcd_100, u_if.o_bcd_10, u_if.o_bcd_1}, 16'h0000);
    chk("rst1234_running", {15'd0, u_if.o_running}, 16'd0);

    // Count to 9999, then one more edge wraps to 0 with a one-cycle pulse.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tick_edges(9999);
    chk("c9999_digits", {u_if.o_bcd_1000, u_if.o_bcd_100, u_if.o_bcd_10, u_if.o_bcd_1}, 16'h9999);
    chk("c9999_wrap", {15'd0, u_if.o_wrap}, 16'd0);
    tick_edges(1);
    chk("wrap_count", {2'b00, u_if.o_count}, 16'd0);
    chk("wrap_pulse", {15'd0, u_if.o_wrap}, 16'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_after", {15'd0, u_if.o_wrap}, 16'd0);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_drained", 16'(q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
